squash_rom_loader: RTL
======================

// Module: squash_rom_loader
// PURPOSE
//  Consumes the hps_io ioctl download stream and produces the core ROM write port (dn_addr/dn_data/dn_wr).
//  Registers each write, decodes it into one of three ROM regions (CPU, GFX, SND) and drops out-of-range bytes.
//  Holds the game core in reset until a complete image has loaded.
//  Sits between hps_io and the Pickin core in the emu top level; replaces the ad-hoc initReset_n logic.
// PARAMETERS
//  ADDR_W    17        width of dn_addr and of the in-range address compare
//  CPU_END   'h08000   first byte past the CPU ROM region (CPU = [0, CPU_END))
//  GFX_END   'h10000   first byte past the GFX ROM region (GFX = [CPU_END, GFX_END))
//  TOTAL     'h18000   image size; SND = [GFX_END, TOTAL); addresses >= TOTAL are dropped
//  CHK_REF   16'h0000  expected 16-bit byte sum (used only with SQUASH_ROM_CHECKSUM_EN)
// PORTS
//  clk_sys         in   1       system clock (12 MHz)
//  reset_n         in   1       asynchronous, active-low reset
//  ioctl_download  in   1       download window from hps_io
//  ioctl_wr        in   1       byte strobe from hps_io, one cycle per byte
//  ioctl_addr      in   25      byte address from hps_io
//  ioctl_dout      in   8       byte data from hps_io
//  dn_addr         out  ADDR_W  registered ROM write address
//  dn_data         out  8       registered ROM write data
//  dn_wr           out  1       one-cycle write pulse to the core
//  dn_rgn          out  3       one-hot region for the current dn_wr: [0] CPU, [1] GFX, [2] SND
//  core_reset_n    out  1       0 = hold core in reset; 1 only in state DONE
//  load_busy       out  1       1 while in state LOAD
//  load_err        out  1       sticky: short image, overflow, or checksum mismatch
//  byte_cnt        out  ADDR_W+1  accepted-byte count, saturating
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE; dn_addr=0, dn_data=0, dn_wr=0, dn_rgn=0, core_reset_n=0,
//    load_busy=0, load_err=0, byte_cnt=0. Internal download edge register=0.
//  - States:
//    - IDLE: no image loaded.
//    - LOAD: rising edge of ioctl_download, from any state. Clears byte_cnt, load_err and the checksum.
//    - DONE: falling edge in LOAD with byte_cnt >= TOTAL and no error.
//    - ERR: falling edge in LOAD otherwise. Stays until the next rising edge.
//  - Edge detect: ioctl_download is sampled into a register; rise = cur & ~prev, fall = ~cur & prev.
//  - Accept condition: ioctl_wr & ioctl_download & (ioctl_addr < TOTAL), with the compare done on all 25 bits.
//    A write in the same cycle as the rising edge is accepted and counted after the clear.
//  - Latency: an accepted write at cycle N gives dn_wr=1 at N+1, with dn_addr=ioctl_addr[ADDR_W-1:0],
//    dn_data and dn_rgn valid in that same cycle.
//    Back-to-back strobes give back-to-back dn_wr pulses; no stall and no loss.
//  - dn_rgn is 0 whenever dn_wr=0. dn_addr and dn_data hold their last value between pulses.
//  - Out-of-range write (addr >= TOTAL while downloading): no dn_wr; load_err<=1; byte_cnt unchanged.
//  - ioctl_wr while ioctl_download=0: ignored entirely (no dn_wr, no count, no error).
//  - byte_cnt counts accepted writes and saturates at 2^(ADDR_W+1)-1.
//    Duplicate addresses are each counted (no dedupe).
//  - core_reset_n: 1 only in DONE; drops to 0 the cycle after a rising edge and stays 0 through LOAD, IDLE and ERR.
//  - load_busy = (state==LOAD). load_err is visible from the cycle it is set.
//  - reset_n asserted mid-LOAD: immediate return to IDLE; a pending dn_wr is cancelled.
//    The next image load needs a fresh rising edge.
// CONFIGURATION
//  SQUASH_ROM_CHECKSUM_EN defined:
//    - Adds a 16-bit wrapping sum of dn_data on every dn_wr, cleared on entry to LOAD.
//    - On the falling edge, sum != CHK_REF forces ERR and sets load_err.
//    - The compare uses the sum including a dn_wr that issues in the falling-edge cycle.
//  Undefined: no sum logic; CHK_REF is unused; DONE/ERR depend only on count and overflow.
// TESTING
//  - Reset, then idle 10 cycles: all outputs 0, core_reset_n=0, state IDLE.
//  - Full load of bytes 0..'h17FFF, data=addr[7:0], one strobe every 4 cycles, then drop download:
//    dn_wr count='h18000; dn_rgn=001 at 'h07FFF and 010 at 'h08000, 100 at 'h17FFF;
//    byte_cnt='h18000; core_reset_n=1 one cycle after the fall; load_err=0.
//  - Short load: 'h100 bytes then drop -> state ERR, load_err=1, core_reset_n stays 0.
//  - Write at ioctl_addr='h18000 and at 'h1000000 during a full load:
//    no dn_wr for either; load_err=1; final state ERR.
//  - Back-to-back strobes (addrs 0,1,2 on consecutive cycles):
//    dn_wr high 3 consecutive cycles, dn_addr 0,1,2 each one cycle late.
//    Then reset_n=0 mid-stream: all outputs 0 immediately.
//  - With SQUASH_ROM_CHECKSUM_EN and CHK_REF set to the image sum: DONE.
//    Same run with CHK_REF+1: ERR, load_err=1.

Source files
------------

// File: rtl/squash_rom_loader_if.sv
// squash_rom_loader_if
//   Bundles the hps_io ioctl download stream and the ROM write port of the
//   core into one interface.
//   Signals:
//     ioctl_download  download window from hps_io
//     ioctl_wr        one-cycle byte strobe from hps_io
//     ioctl_addr      25-bit byte address from hps_io
//     ioctl_dout      byte data from hps_io
//     dn_addr         registered ROM write address (ADDR_W bits)
//     dn_data         registered ROM write data
//     dn_wr           one-cycle ROM write pulse
//     dn_rgn          one-hot region of the current dn_wr: [0] CPU, [1] GFX, [2] SND
//   Modports:
//     master  hps_io / core side (drives ioctl_*, observes dn_*)
//     slave   the loader itself (observes ioctl_*, drives dn_*)
interface squash_rom_loader_if #(
    parameter int ADDR_W = 17
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_wr;
    logic [2:0]        dn_rgn;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr, dn_rgn
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr, dn_rgn
    );
endinterface

// File: rtl/squash_rom_loader.sv
// squash_rom_loader
//   Turns the hps_io ioctl download stream into the core ROM write port.
//   Each in-range byte is registered, tagged with its ROM region (CPU, GFX,
//   SND) and forwarded one cycle later; bytes at or beyond TOTAL are dropped
//   and flagged. The core is held in reset until a complete image has loaded.
//   Optional feature macro: SQUASH_ROM_CHECKSUM_EN adds a 16-bit byte sum that
//   must equal CHK_REF at the end of the download.
//   Ports:
//     clk_sys       system clock
//     reset_n       asynchronous active-low reset
//     bus           squash_rom_loader_if.slave (ioctl_* in, dn_* out)
//     core_reset_n  0 holds the core in reset; 1 only once an image is DONE
//     load_busy     1 while a download is in progress
//     load_err      sticky: short image, overflow or checksum mismatch
//     byte_cnt      saturating count of accepted bytes
module squash_rom_loader #(
    parameter int          ADDR_W  = 17,
    parameter logic [24:0] CPU_END = 25'h08000,
    parameter logic [24:0] GFX_END = 25'h10000,
    parameter logic [24:0] TOTAL   = 25'h18000,
    parameter logic [15:0] CHK_REF = 16'h0000
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    squash_rom_loader_if.slave   bus,
    output logic                 core_reset_n,
    output logic                 load_busy,
    output logic                 load_err,
    output logic [ADDR_W:0]      byte_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] CNT_MAX   = '1;
    localparam logic [ADDR_W:0] CNT_ONE   = 1;
    localparam logic [ADDR_W:0] TOTAL_CNT = TOTAL[ADDR_W:0];

    state_t            state;
    state_t            state_next;
    logic              dl_prev;
    logic              rise;
    logic              fall;
    logic              in_range;
    logic              accept;
    logic              overflow;
    logic [2:0]        rgn_next;
    logic [ADDR_W:0]   cnt_base;
    logic [ADDR_W:0]   cnt_next;
    logic              err_next;
    logic              chk_ok;

    logic [ADDR_W-1:0] dn_addr_q;
    logic [7:0]        dn_data_q;
    logic              dn_wr_q;
    logic [2:0]        dn_rgn_q;

    // The range compare runs on the full 25-bit address so that a high
    // address cannot alias back into the image through truncation.
    always_comb begin
        rise     = bus.ioctl_download & ~dl_prev;
        fall     = ~bus.ioctl_download & dl_prev;
        in_range = (bus.ioctl_addr < TOTAL);
        accept   = bus.ioctl_wr & bus.ioctl_download & in_range;
        overflow = bus.ioctl_wr & bus.ioctl_download & ~in_range;
        if (bus.ioctl_addr < CPU_END) begin
            rgn_next = 3'b001;
        end else if (bus.ioctl_addr < GFX_END) begin
            rgn_next = 3'b010;
        end else begin
            rgn_next = 3'b100;
        end
    end

    // A rising edge clears the count first, so a write arriving in that
    // same cycle is counted as the first byte of the new image.
    always_comb begin
        cnt_base = rise ? '0 : byte_cnt;
        cnt_next = cnt_base;
        if (accept && (cnt_base != CNT_MAX)) begin
            cnt_next = cnt_base + CNT_ONE;
        end
    end

`ifdef SQUASH_ROM_CHECKSUM_EN
    logic [15:0] chk_sum;
    logic [15:0] chk_final;

    // The end-of-load compare must include a dn_wr that is still issuing in
    // the falling-edge cycle, so the pending byte is folded in here.
    always_comb begin
        chk_final = chk_sum + (dn_wr_q ? {8'h00, dn_data_q} : 16'h0000);
        chk_ok    = (chk_final == CHK_REF);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            chk_sum <= 16'h0000;
        end else if (rise) begin
            chk_sum <= 16'h0000;
        end else if (dn_wr_q) begin
            chk_sum <= chk_final;
        end
    end
`else
    logic unused_chk_ref;

    assign unused_chk_ref = ^CHK_REF;
    assign chk_ok         = 1'b1;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Load error is sampled before the update; an overflow can never land in
    // the falling-edge cycle because the download window is already closed.
    always_comb begin
        state_next = state;
        if (rise) begin
            state_next = S_LOAD;
        end else if ((state == S_LOAD) && fall) begin
            if ((byte_cnt >= TOTAL_CNT) && !load_err && chk_ok) begin
                state_next = S_DONE;
            end else begin
                state_next = S_ERR;
            end
        end
    end

    always_comb begin
        core_reset_n = (state == S_DONE);
        load_busy    = (state == S_LOAD);
    end

    always_comb begin
        err_next = rise ? 1'b0 : load_err;
        if (overflow) begin
            err_next = 1'b1;
        end else if ((state == S_LOAD) && fall && (state_next == S_ERR)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_prev   <= 1'b0;
            byte_cnt  <= '0;
            load_err  <= 1'b0;
            dn_addr_q <= '0;
            dn_data_q <= 8'h00;
            dn_wr_q   <= 1'b0;
            dn_rgn_q  <= 3'b000;
        end else begin
            dl_prev  <= bus.ioctl_download;
            byte_cnt <= cnt_next;
            load_err <= err_next;
            dn_wr_q  <= accept;
            dn_rgn_q <= accept ? rgn_next : 3'b000;
            if (accept) begin
                dn_addr_q <= bus.ioctl_addr[ADDR_W-1:0];
                dn_data_q <= bus.ioctl_dout;
            end
        end
    end

    assign bus.dn_addr = dn_addr_q;
    assign bus.dn_data = dn_data_q;
    assign bus.dn_wr   = dn_wr_q;
    assign bus.dn_rgn  = dn_rgn_q;

endmodule
